// File: rtl/dx_bidir_pkg.sv
// Shared state encoding and phase-counter helpers for the dx_bidir bus controller.
package dx_bidir_pkg;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned SYNC_CYCLES = 2;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StDrive = 3'd1;
  localparam logic [2:0] StTurn  = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StSync  = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  // Phase counter load value for an N-cycle phase; the phase ends when the count hits 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/dx_bidir_sync.sv
// DATA_WIDTH-wide two-flop synchronizer for the pad return path.
module dx_bidir_sync #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] meta_q;
  logic [DATA_WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dx_bidir_bus_ctrl.sv
// Half-duplex read/write sequencer for one shared tri-state bus (dx_iobuf pad).
// Optional DX_BIDIR_SYNC_EN: synchronize dio_o and add a 2-cycle SYNC phase to reads.
module dx_bidir_bus_ctrl
  import dx_bidir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned TURN_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bus_stb,
  output logic [DATA_WIDTH-1:0] dio_i,
  output logic [DATA_WIDTH-1:0] dio_t,
  input  logic [DATA_WIDTH-1:0] dio_o
);

  localparam logic [CNT_W-1:0] StbLoad  = cnt_load(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] TurnLoad = cnt_load(TURN_CYCLES);
  localparam logic [CNT_W-1:0] SyncLoad = cnt_load(SYNC_CYCLES);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  stb_q, stb_d;
  logic [DATA_WIDTH-1:0] dio_i_q, dio_i_d;
  logic [DATA_WIDTH-1:0] dio_t_q, dio_t_d;
  logic [DATA_WIDTH-1:0] cap_src;

`ifdef DX_BIDIR_SYNC_EN
  dx_bidir_sync #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (dio_o),
    .q_o    (cap_src)
  );
`else
  assign cap_src = dio_o;
`endif

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    stb_d       = 1'b0;
    dio_i_d     = '0;
    dio_t_d     = '1;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          cnt_d = StbLoad;
          stb_d = 1'b1;
          if (cmd_write) begin
            state_d = StDrive;
            dio_t_d = '0;
            dio_i_d = cmd_wdata;
          end else begin
            state_d = StRead;
          end
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          if (TURN_CYCLES != 0) begin
            state_d = StTurn;
            cnt_d   = TurnLoad;
          end else begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
          end
        end else begin
          cnt_d   = cnt_q - 1'b1;
          stb_d   = 1'b1;
          dio_t_d = '0;
          dio_i_d = dio_i_q;
        end
      end
      StTurn: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRead: begin
        if (cnt_q == '0) begin
`ifdef DX_BIDIR_SYNC_EN
          state_d = StSync;
          cnt_d   = SyncLoad;
`else
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = cap_src;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
          stb_d = 1'b1;
        end
      end
      StSync: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = cap_src;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      stb_q       <= 1'b0;
      dio_i_q     <= '0;
      dio_t_q     <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      stb_q       <= stb_d;
      dio_i_q     <= dio_i_d;
      dio_t_q     <= dio_t_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_stb   = stb_q;
  assign dio_i     = dio_i_q;
  assign dio_t     = dio_t_q;

endmodule

// File: tb/tb_dx_bidir_bus_ctrl.sv
// Directed bench for dx_bidir_bus_ctrl: DUT a (STROBE=2, TURN=1) and DUT b (STROBE=2, TURN=0).
module tb_dx_bidir_bus_ctrl;

`ifdef DX_BIDIR_SYNC_EN
  localparam int ReadLat = 5;
`else
  localparam int ReadLat = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_write, bus_stb;
  logic [7:0] cmd_wdata, rsp_rdata, dio_i, dio_t, dio_o, pad_drv;
  logic       cmd_valid_b, cmd_ready_b, cmd_write_b, rsp_valid_b, rsp_ready_b, rsp_write_b;
  logic       bus_stb_b;
  logic [7:0] cmd_wdata_b, rsp_rdata_b, dio_i_b, dio_t_b, dio_o_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Pad model: the external device drives the pad wherever the controller has released it.
  assign dio_o   = (dio_t & pad_drv) | (~dio_t & dio_i);
  assign dio_o_b = (dio_t_b & pad_drv) | (~dio_t_b & dio_i_b);

  dx_bidir_bus_ctrl #(
    .DATA_WIDTH    (8),
    .STROBE_CYCLES (2),
    .TURN_CYCLES   (1)
  ) dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .bus_stb   (bus_stb),
    .dio_i     (dio_i),
    .dio_t     (dio_t),
    .dio_o     (dio_o)
  );

  dx_bidir_bus_ctrl #(
    .DATA_WIDTH    (8),
    .STROBE_CYCLES (2),
    .TURN_CYCLES   (0)
  ) dut_b (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid_b),
    .cmd_ready (cmd_ready_b),
    .cmd_write (cmd_write_b),
    .cmd_wdata (cmd_wdata_b),
    .rsp_valid (rsp_valid_b),
    .rsp_ready (rsp_ready_b),
    .rsp_write (rsp_write_b),
    .rsp_rdata (rsp_rdata_b),
    .bus_stb   (bus_stb_b),
    .dio_i     (dio_i_b),
    .dio_t     (dio_t_b),
    .dio_o     (dio_o_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_wdata   = 8'h00;
    rsp_ready   = 1'b0;
    cmd_valid_b = 1'b0;
    cmd_write_b = 1'b0;
    cmd_wdata_b = 8'h00;
    rsp_ready_b = 1'b0;
    pad_drv     = 8'h00;

    // Reset state
    step();
    step();
    chk("rst_dio_t", dio_t, 8'hFF);
    chk("rst_dio_i", dio_i, 8'h00);
    chk("rst_stb", bus_stb, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_write", rsp_write, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_dio_t_b", dio_t_b, 8'hFF);
    resetn = 1'b1;
    step();
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_cmd_ready_b", cmd_ready_b, 1'b1);

    // TURN_CYCLES=0: write response on cycle 3, bus released right after the strobe
    cmd_valid_b = 1'b1;
    cmd_write_b = 1'b1;
    cmd_wdata_b = 8'h96;
    step();
    cmd_valid_b = 1'b0;
    chk("b_c1_dio_t", dio_t_b, 8'h00);
    chk("b_c1_dio_i", dio_i_b, 8'h96);
    chk("b_c1_stb", bus_stb_b, 1'b1);
    step();
    chk("b_c2_dio_t", dio_t_b, 8'h00);
    chk("b_c2_stb", bus_stb_b, 1'b1);
    chk("b_c2_rsp_valid", rsp_valid_b, 1'b0);
    step();
    chk("b_c3_dio_t", dio_t_b, 8'hFF);
    chk("b_c3_stb", bus_stb_b, 1'b0);
    chk("b_c3_rsp_valid", rsp_valid_b, 1'b1);
    chk("b_c3_rsp_write", rsp_write_b, 1'b1);
    chk("b_c3_rsp_rdata", rsp_rdata_b, 8'h00);
    rsp_ready_b = 1'b1;
    step();
    rsp_ready_b = 1'b0;
    chk("b_hs_rsp_valid", rsp_valid_b, 1'b0);
    chk("b_hs_cmd_ready", cmd_ready_b, 1'b1);

    // Write 0xA5: 2 drive cycles, 1 turnaround, response on cycle 4
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 8'hA5;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      chk($sformatf("wr_c%0d_dio_t", c), dio_t, 8'h00);
      chk($sformatf("wr_c%0d_dio_i", c), dio_i, 8'hA5);
      chk($sformatf("wr_c%0d_stb", c), bus_stb, 1'b1);
      chk($sformatf("wr_c%0d_cmd_ready", c), cmd_ready, 1'b0);
      step();
    end
    chk("wr_c3_dio_t", dio_t, 8'hFF);
    chk("wr_c3_dio_i", dio_i, 8'h00);
    chk("wr_c3_stb", bus_stb, 1'b0);
    chk("wr_c3_rsp_valid", rsp_valid, 1'b0);
    step();
    chk("wr_c4_rsp_valid", rsp_valid, 1'b1);
    chk("wr_c4_rsp_write", rsp_write, 1'b1);
    chk("wr_c4_rsp_rdata", rsp_rdata, 8'h00);
    chk("wr_c4_dio_t", dio_t, 8'hFF);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_hs_rsp_valid", rsp_valid, 1'b0);
    chk("wr_hs_cmd_ready", cmd_ready, 1'b1);

    // Read, pad drives 0x3C
    pad_drv   = 8'h3C;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      chk($sformatf("rd_c%0d_stb", c), bus_stb, 1'b1);
      chk($sformatf("rd_c%0d_dio_t", c), dio_t, 8'hFF);
      step();
    end
    for (int c = 3; c < ReadLat; c++) begin
      chk($sformatf("rd_c%0d_stb", c), bus_stb, 1'b0);
      chk($sformatf("rd_c%0d_rsp_valid", c), rsp_valid, 1'b0);
      step();
    end
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_write", rsp_write, 1'b0);
    chk("rd_rsp_rdata", rsp_rdata, 8'h3C);
    chk("rd_rsp_dio_t", dio_t, 8'hFF);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_hs_rsp_valid", rsp_valid, 1'b0);

    // Response stall: hold rsp_ready low 10 cycles while commands are offered
    pad_drv   = 8'h5A;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c < ReadLat; c++) step();
    chk("st_rsp_valid0", rsp_valid, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 8'h11;
    pad_drv   = 8'h00;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("st_c%0d_rsp_valid", c), rsp_valid, 1'b1);
      chk($sformatf("st_c%0d_rsp_rdata", c), rsp_rdata, 8'h5A);
      chk($sformatf("st_c%0d_cmd_ready", c), cmd_ready, 1'b0);
      chk($sformatf("st_c%0d_stb", c), bus_stb, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("st_hs_rsp_valid", rsp_valid, 1'b0);
    chk("st_hs_cmd_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    chk("st_acc_dio_t", dio_t, 8'h00);
    chk("st_acc_dio_i", dio_i, 8'h11);
    chk("st_acc_stb", bus_stb, 1'b1);
    for (int c = 1; c < 4; c++) step();
    chk("st_wr_rsp_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Back-to-back write then read with rsp_ready tied high
    pad_drv   = 8'hE7;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 8'hC3;
    step();
    cmd_write = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("bb_c%0d_dio_t", c), dio_t, (c <= 2) ? 8'h00 : 8'hFF);
      chk($sformatf("bb_c%0d_stb", c), bus_stb, (c <= 2 || c >= 6) ? 1'b1 : 1'b0);
      chk($sformatf("bb_c%0d_rsp_valid", c), rsp_valid, (c == 4) ? 1'b1 : 1'b0);
      if (c == 5) chk("bb_c5_cmd_ready", cmd_ready, 1'b1);
      if (c == 6) cmd_valid = 1'b0;
      step();
    end
    for (int c = 8; c < 5 + ReadLat; c++) begin
      chk($sformatf("bb_c%0d_dio_t", c), dio_t, 8'hFF);
      chk($sformatf("bb_c%0d_rsp_valid", c), rsp_valid, 1'b0);
      step();
    end
    chk("bb_rd_rsp_valid", rsp_valid, 1'b1);
    chk("bb_rd_rsp_write", rsp_write, 1'b0);
    chk("bb_rd_rsp_rdata", rsp_rdata, 8'hE7);
    step();
    rsp_ready = 1'b0;
    chk("bb_hs_rsp_valid", rsp_valid, 1'b0);

    // Asynchronous reset in the 2nd drive cycle releases the bus with no clock edge
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 8'h5F;
    step();
    cmd_valid = 1'b0;
    step();
    chk("ar_c2_dio_t", dio_t, 8'h00);
    chk("ar_c2_stb", bus_stb, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_dio_t", dio_t, 8'hFF);
    chk("ar_stb", bus_stb, 1'b0);
    chk("ar_dio_i", dio_i, 8'h00);
    chk("ar_cmd_ready", cmd_ready, 1'b0);
    step();
    resetn = 1'b1;
    step();
    step();
    step();
    chk("ar_post_rsp_valid", rsp_valid, 1'b0);
    chk("ar_post_cmd_ready", cmd_ready, 1'b1);
    chk("ar_post_dio_t", dio_t, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
